// File: rtl/midterm_alu_128.sv
// Registered two-mode ALU (arithmetic / bitwise logic) with carry, zero, overflow and sign flags.
// Optional macro ALU_SATURATE_EN clamps overflowing ADD/SUB/INC/DEC/NEG results.
module midterm_alu_128 #(
   parameter int unsigned WIDTH = 128
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   input  logic [2:0]       opsel,
   input  logic             mode,
   output logic [WIDTH-1:0] result,
   output logic             c_flag,
   output logic             z_flag,
   output logic             o_flag,
   output logic             s_flag
);

   localparam int unsigned MSB = WIDTH - 1;

   localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH:0]   ONE_X = (WIDTH+1)'(1);

   logic [WIDTH-1:0] result_d, result_q;
   logic             c_d, c_q;
   logic             z_d, z_q;
   logic             o_d, o_q;
   logic             s_d, s_q;

   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] res;
   logic             c_c;
   logic             o_c;

   // Combinational compute: one adder expression per arithmetic op, full decode of {mode, opsel}
   always_comb begin
      sum = '0;
      res = '0;
      c_c = 1'b0;
      o_c = 1'b0;
      case ({mode, opsel})
         4'b0_000: begin
            sum = {1'b0, op1} + {1'b0, op2};
            res = sum[MSB:0];
            c_c = sum[WIDTH];
            o_c = (op1[MSB] == op2[MSB]) && (res[MSB] != op1[MSB]);
         end
         4'b0_001: begin
            sum = {1'b0, op1} + {1'b0, ~op2} + ONE_X;
            res = sum[MSB:0];
            c_c = sum[WIDTH];
            o_c = (op1[MSB] != op2[MSB]) && (res[MSB] != op1[MSB]);
         end
         4'b0_010: begin
            sum = {1'b0, op1} + ONE_X;
            res = sum[MSB:0];
            c_c = sum[WIDTH];
            o_c = (op1 == SMAX);
         end
         4'b0_011: begin
            sum = {1'b0, op1} + {1'b0, {WIDTH{1'b1}}};
            res = sum[MSB:0];
            c_c = sum[WIDTH];
            o_c = (op1 == SMIN);
         end
         4'b0_100: begin
            sum = {1'b0, ~op1} + ONE_X;
            res = sum[MSB:0];
            c_c = sum[WIDTH];
            o_c = (op1 == SMIN);
         end
         4'b0_101: begin
            res = {op1[MSB-1:0], 1'b0};
            c_c = op1[MSB];
            o_c = op1[MSB] ^ op1[MSB-1];
         end
         4'b0_110: begin
            res = {op1[MSB], op1[MSB:1]};
            c_c = op1[0];
         end
         4'b1_000: res = op1 & op2;
         4'b1_001: res = op1 | op2;
         4'b1_010: res = op1 ^ op2;
         4'b1_011: res = ~op1;
         4'b1_100: res = ~(op1 ^ op2);
         default:  res = '0;
      endcase
   end

   // Next-state: capture on en, optional clamp, flags derived from the final result
   always_comb begin
      result_d = result_q;
      c_d      = c_q;
      z_d      = z_q;
      o_d      = o_q;
      s_d      = s_q;
      if (en) begin
         result_d = res;
`ifdef ALU_SATURATE_EN
         // Wrapped MSB set means the true value was positive, and vice versa
         if (!mode && (opsel <= 3'd4) && o_c)
            result_d = res[MSB] ? SMAX : SMIN;
`endif
         c_d = c_c;
         o_d = o_c;
         z_d = (result_d == '0);
         s_d = result_d[MSB];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= '0;
         c_q      <= 1'b0;
         z_q      <= 1'b0;
         o_q      <= 1'b0;
         s_q      <= 1'b0;
      end else begin
         result_q <= result_d;
         c_q      <= c_d;
         z_q      <= z_d;
         o_q      <= o_d;
         s_q      <= s_d;
      end
   end

   assign result = result_q;
   assign c_flag = c_q;
   assign z_flag = z_q;
   assign o_flag = o_q;
   assign s_flag = s_q;

endmodule

// File: tb/tb_midterm_alu_128.sv
// Directed self-checking bench for midterm_alu_128; expectations follow ALU_SATURATE_EN when defined.
module tb_midterm_alu_128;

   logic         clk;
   logic         rst_n;
   logic         en;
   logic [127:0] op1;
   logic [127:0] op2;
   logic [2:0]   opsel;
   logic         mode;
   logic [127:0] result;
   logic         c_flag, z_flag, o_flag, s_flag;

   int passed;
   int total;

   localparam logic [127:0] A    = 128'h8000_0000_0000_0000_0000_0000_0000_0005;
   localparam logic [127:0] B    = 128'h8000_0000_0000_0000_0000_0000_0000_0009;
   localparam logic [127:0] SMAX = 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
   localparam logic [127:0] SMIN = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
   localparam logic [127:0] ONES = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;

   logic [127:0] exp_r [8];
   logic [3:0]   exp_f [8];   // {c, z, o, s}
   logic [127:0] v1 [10];
   logic [127:0] v2 [10];
   logic [2:0]   vs [10];

   midterm_alu_128 #(.WIDTH(128)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .op1    (op1),
      .op2    (op2),
      .opsel  (opsel),
      .mode   (mode),
      .result (result),
      .c_flag (c_flag),
      .z_flag (z_flag),
      .o_flag (o_flag),
      .s_flag (s_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one operation at the falling edge and return 1 ns after the capturing edge
   task automatic drive(input logic m, input logic [2:0] sel, input logic [127:0] a,
                        input logic [127:0] b, input logic e);
      @(negedge clk);
      mode  = m;
      opsel = sel;
      op1   = a;
      op2   = b;
      en    = e;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      en    = 1'b1;
      mode  = 1'b0;
      opsel = 3'd0;
      op1   = A;
      op2   = B;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({result, c_flag, z_flag, o_flag, s_flag} !== {128'h0, 4'b0000})
         $display("FAIL reset: got %h flags %b, want 0 flags 0000", result,
                  {c_flag, z_flag, o_flag, s_flag});
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_arith();
      exp_r[0] = 128'h0000_0000_0000_0000_0000_0000_0000_000E; exp_f[0] = 4'b1010;
`ifdef ALU_SATURATE_EN
      exp_r[0] = SMIN; exp_f[0] = 4'b1011;
`endif
      exp_r[1] = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFC; exp_f[1] = 4'b0001;
      exp_r[2] = 128'h8000_0000_0000_0000_0000_0000_0000_0006; exp_f[2] = 4'b0001;
      exp_r[3] = 128'h8000_0000_0000_0000_0000_0000_0000_0004; exp_f[3] = 4'b1001;
      exp_r[4] = 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFB; exp_f[4] = 4'b0000;
      exp_r[5] = 128'h0000_0000_0000_0000_0000_0000_0000_000A; exp_f[5] = 4'b1010;
      exp_r[6] = 128'hC000_0000_0000_0000_0000_0000_0000_0002; exp_f[6] = 4'b1001;
      exp_r[7] = 128'h0;                                      exp_f[7] = 4'b0100;
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 3'(i), A, B, 1'b1);
         total++;
         if (result !== exp_r[i])
            $display("FAIL arith op%0d result: got %h want %h", i, result, exp_r[i]);
         else passed++;
         total++;
         if ({c_flag, z_flag, o_flag, s_flag} !== exp_f[i])
            $display("FAIL arith op%0d flags czos: got %b want %b", i,
                     {c_flag, z_flag, o_flag, s_flag}, exp_f[i]);
         else passed++;
      end
   endtask

   task automatic test_logic();
      exp_r[0] = 128'h8000_0000_0000_0000_0000_0000_0000_0001; exp_f[0] = 4'b0001;
      exp_r[1] = 128'h8000_0000_0000_0000_0000_0000_0000_000D; exp_f[1] = 4'b0001;
      exp_r[2] = 128'h0000_0000_0000_0000_0000_0000_0000_000C; exp_f[2] = 4'b0000;
      exp_r[3] = 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFA; exp_f[3] = 4'b0000;
      exp_r[4] = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF3; exp_f[4] = 4'b0001;
      for (int i = 5; i < 8; i++) begin
         exp_r[i] = 128'h0; exp_f[i] = 4'b0100;
      end
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 3'(i), A, B, 1'b1);
         total++;
         if (result !== exp_r[i])
            $display("FAIL logic op%0d result: got %h want %h", i, result, exp_r[i]);
         else passed++;
         total++;
         if ({c_flag, z_flag, o_flag, s_flag} !== exp_f[i])
            $display("FAIL logic op%0d flags czos: got %b want %b", i,
                     {c_flag, z_flag, o_flag, s_flag}, exp_f[i]);
         else passed++;
      end
   endtask

   // Overflow corners and wrap limits, issued back to back one per cycle
   task automatic test_boundary();
      logic [127:0] er [10];
      logic [3:0]   ef [10];
      v1[0] = SMAX; v2[0] = 128'h1; vs[0] = 3'd0; er[0] = SMIN; ef[0] = 4'b0011;
      v1[1] = SMAX; v2[1] = 128'h0; vs[1] = 3'd2; er[1] = SMIN; ef[1] = 4'b0011;
      v1[2] = 128'h0; v2[2] = 128'h0; vs[2] = 3'd3; er[2] = ONES; ef[2] = 4'b0001;
      v1[3] = SMIN; v2[3] = 128'h0; vs[3] = 3'd3; er[3] = SMAX; ef[3] = 4'b1010;
      v1[4] = 128'h0; v2[4] = 128'h0; vs[4] = 3'd4; er[4] = 128'h0; ef[4] = 4'b1100;
      v1[5] = SMIN; v2[5] = 128'h0; vs[5] = 3'd4; er[5] = SMIN; ef[5] = 4'b0011;
      v1[6] = 128'h0; v2[6] = 128'h1; vs[6] = 3'd1; er[6] = ONES; ef[6] = 4'b0001;
      v1[7] = SMIN; v2[7] = 128'h1; vs[7] = 3'd1; er[7] = SMAX; ef[7] = 4'b1010;
      v1[8] = 128'h4000_0000_0000_0000_0000_0000_0000_0000; v2[8] = 128'h0; vs[8] = 3'd5;
      er[8] = SMIN; ef[8] = 4'b0011;
      v1[9] = 128'h5; v2[9] = 128'h5; vs[9] = 3'd1; er[9] = 128'h0; ef[9] = 4'b1100;
`ifdef ALU_SATURATE_EN
      er[0] = SMAX; ef[0] = 4'b0010;
      er[1] = SMAX; ef[1] = 4'b0010;
      er[3] = SMIN; ef[3] = 4'b1011;
      er[5] = SMAX; ef[5] = 4'b0010;
      er[7] = SMIN; ef[7] = 4'b1011;
`endif
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, vs[i], v1[i], v2[i], 1'b1);
         total++;
         if (result !== er[i])
            $display("FAIL boundary #%0d result: got %h want %h", i, result, er[i]);
         else passed++;
         total++;
         if ({c_flag, z_flag, o_flag, s_flag} !== ef[i])
            $display("FAIL boundary #%0d flags czos: got %b want %b", i,
                     {c_flag, z_flag, o_flag, s_flag}, ef[i]);
         else passed++;
      end
   endtask

   task automatic test_hold();
      logic [127:0] want_r;
      drive(1'b1, 3'd1, A, B, 1'b1);   // OR -> 0x800...0D, flags 0001
      want_r = 128'h8000_0000_0000_0000_0000_0000_0000_000D;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 3'(i), 128'h0, 128'h1, 1'b0);
         total++;
         if ({result, c_flag, z_flag, o_flag, s_flag} !== {want_r, 4'b0001})
            $display("FAIL hold cycle %0d: got %h flags %b want %h flags 0001", i, result,
                     {c_flag, z_flag, o_flag, s_flag}, want_r);
         else passed++;
      end
   endtask

   task automatic test_async_reset();
      drive(1'b0, 3'd6, A, B, 1'b1);   // ASR leaves nonzero result and c/s set
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({result, c_flag, z_flag, o_flag, s_flag} !== {128'h0, 4'b0000})
         $display("FAIL async reset: got %h flags %b, want 0 flags 0000", result,
                  {c_flag, z_flag, o_flag, s_flag});
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 3'd2, A, B, 1'b1);   // XOR after release
      total++;
      if ({result, c_flag, z_flag, o_flag, s_flag} !== {128'hC, 4'b0000})
         $display("FAIL after reset release: got %h flags %b want c flags 0000", result,
                  {c_flag, z_flag, o_flag, s_flag});
      else passed++;
   endtask

   initial begin
      passed = 0;
      total  = 0;
      test_reset();
      test_arith();
      test_logic();
      test_boundary();
      test_hold();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/midterm_alu_128.md
Name: midterm_alu_128

Overview:
- Registered 128-bit ALU with two modes: arithmetic (`mode`=0, 7 ops) and bitwise logic (`mode`=1, 5 ops).
- Produces a result plus carry, zero, overflow and sign flags.
- Sits as a datapath execute stage: combinational compute, then one output register stage.

Parameters:
- WIDTH, 128, operand/result width in bits (all rules below scale with WIDTH; MSB = WIDTH-1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  capture enable; 1 = register new result/flags this edge.
- op1  input  WIDTH  operand A.
- op2  input  WIDTH  operand B.
- opsel  input  3  operation select within mode.
- mode  input  1  0 = arithmetic, 1 = logic.
- result  output  WIDTH  registered result.
- c_flag  output  1  registered carry/shift-out.
- z_flag  output  1  registered zero flag.
- o_flag  output  1  registered signed overflow.
- s_flag  output  1  registered sign (result MSB).

Behaviour:
- Reset:
  - rst_n low clears result, c_flag, z_flag, o_flag and s_flag to 0 immediately, regardless of clk.
  - Release is synchronous to the next rising edge.
- Latency and enable:
  - 1 cycle: inputs sampled at a rising edge with en=1 appear on outputs after that edge.
  - en=0: all outputs hold.
- Arithmetic mode (`mode`=0), two's complement:
  - 000 ADD: op1+op2; c = carry out of MSB; o = (op1[MSB]==op2[MSB]) && (result[MSB]!=op1[MSB]).
  - 001 SUB: op1-op2, computed as op1+~op2+1; c = carry out (1 = no borrow); o = (op1[MSB]!=op2[MSB]) && (result[MSB]!=op1[MSB]).
  - 010 INC: op1+1; c = carry out; o = 1 only when op1 = 0x7FF…F.
  - 011 DEC: op1-1; c = carry out of op1+all-ones (0 only when op1=0); o = 1 only when op1 = 0x800…0.
  - 100 NEG: 0-op1; c = 1 only when op1=0; o = 1 only when op1 = 0x800…0.
  - 101 SHL: op1<<1, zero fill; c = op1[MSB]; o = op1[MSB]^op1[MSB-1].
  - 110 ASR: arithmetic shift right by 1, sign fill; c = op1[0]; o = 0.
  - 111 reserved: result 0; c=0, o=0.
- Logic mode (`mode`=1):
  - 000 AND, 001 OR, 010 XOR, 011 NOT op1, 100 XNOR.
  - 101–111 reserved: result 0.
  - c=0 and o=0 for every logic op.
- All ops, both modes: z = (result==0); s = result[MSB]. Reserved codes therefore give z=1, s=0.
- Wrap-around: non-saturating; the result is truncated modulo 2^WIDTH.
- No X propagation: every opsel/mode combination is fully decoded.

Optional Feature:
- Macro: ALU_SATURATE_EN.
- Defined: ADD, SUB, INC, DEC and NEG saturate whenever o would be 1.
  - Positive overflow clamps to 0x7FF…F; negative overflow clamps to 0x800…0.
  - o_flag still reports 1; c_flag is unchanged from the non-saturating rule.
  - z and s are computed on the clamped result.
- Not defined: wrap-around as specified above; no saturation logic is synthesised.

Test Plan:
- Common operands, macro undefined: op1=0x8000…0005, op2=0x8000…0009, en=1.
- ADD (mode0,000) -> result 0x000…000E, c=1, o=1, z=0, s=0, one cycle later.
- SUB (mode0,001) -> 0xFFF…FFFC, c=0, o=0, z=0, s=1; INC (010) -> 0x800…0006, s=1, c=0, o=0.
- NEG (mode0,100) -> 0x7FF…FFFB, s=0, c=0, o=0; SHL (101) -> 0x000…000A, c=1, o=1; ASR (110) -> 0xC00…0002, c=1, s=1.
- Logic mode, same operands:
  - AND -> 0x800…0001, s=1.
  - OR -> 0x800…000D.
  - XOR -> 0x000…000C, z=0, s=0.
  - NOT -> 0x7FF…FFFA.
  - opsel 101 -> 0, z=1.
  - All logic cases: c=o=0.
- Control and reset:
  - en=0 for 3 cycles while changing opsel -> outputs hold the last value.
  - Drop rst_n mid-cycle -> all outputs 0 before the next clk edge.
- Saturation, macro defined: ADD of 0x7FF…F + 1 -> 0x7FF…F, o=1, s=0.
  - Same stimulus without the macro -> 0x800…0, o=1, s=1.
